// File: rtl/spike_generator_array.sv
// Time-multiplexed bank of periodic spike generators. Each time unit it scans slots 0..gens_used
// and emits one tag/ct word for every enabled, programmed slot whose countdown reaches zero.
module spike_generator_array #(
  parameter int unsigned Ngens   = 8,
  parameter int unsigned Nperiod = 16,
  parameter int unsigned Ntag    = 11,
  parameter int unsigned Nct     = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  time_unit,
  input  logic [Ngens-1:0]      gens_used,
  input  logic [2**Ngens-1:0]   gens_en,
  input  logic [Ngens-1:0]      prog_gen_idx,
  input  logic [Nperiod-1:0]    prog_period,
  input  logic [Nperiod-1:0]    prog_ticks,
  input  logic [Ntag-1:0]       prog_tag,
  input  logic                  prog_v,
  output logic                  prog_a,
  output logic [Ntag-1:0]       out_tag,
  output logic [Nct-1:0]        out_ct,
  output logic                  out_v,
  input  logic                  out_a,
  output logic                  overrun
);

  localparam int unsigned Nslots = 2**Ngens;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t              state_q;
  logic [Ngens-1:0]    idx_q;
  logic                pending_q;
  logic                overrun_q;
  logic                prog_a_q;
  logic                out_v_q;
  logic [Ntag-1:0]     out_tag_q;
  logic [Nct-1:0]      out_ct_q;
  logic [Nslots-1:0]   programmed_q;

  logic [Nperiod-1:0]  period_mem [Nslots];
  logic [Nperiod-1:0]  ticks_mem  [Nslots];
  logic [Ntag-1:0]     tag_mem    [Nslots];

  logic                prog_xfer;
  logic                slot_active;
  logic                scan_step;
  logic                slot_fire;
  logic                last_slot;
  logic [Nperiod-1:0]  period_rd;
  logic [Nperiod-1:0]  ticks_rd;
  logic [Ntag-1:0]     tag_rd;
  logic [Nperiod-1:0]  ticks_d;

  always_comb begin
    period_rd   = period_mem[idx_q];
    ticks_rd    = ticks_mem[idx_q];
    tag_rd      = tag_mem[idx_q];
    prog_xfer   = (state_q == IDLE) && prog_a_q && prog_v;
    slot_active = programmed_q[idx_q] && gens_en[idx_q] && (period_rd != '0);
    scan_step   = (state_q == SCAN) && slot_active;
    slot_fire   = scan_step && (ticks_rd == '0);
    ticks_d     = slot_fire ? (period_rd - Nperiod'(1)) : (ticks_rd - Nperiod'(1));
    last_slot   = (idx_q == gens_used);
  end

  // Slot storage carries no reset so it can map onto RAM; the programmed bits gate its use.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (prog_xfer) begin
        period_mem[prog_gen_idx] <= prog_period;
        ticks_mem[prog_gen_idx]  <= prog_ticks;
        tag_mem[prog_gen_idx]    <= prog_tag;
      end else if (scan_step) begin
        ticks_mem[idx_q] <= ticks_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      prog_a_q     <= 1'b0;
      out_v_q      <= 1'b0;
      out_tag_q    <= '0;
      out_ct_q     <= '0;
      programmed_q <= '0;
    end else begin
      if (prog_xfer) programmed_q[prog_gen_idx] <= 1'b1;
      // Units arriving while busy queue one deep; a second one is dropped and flagged.
      if (time_unit && (state_q != IDLE)) begin
        if (pending_q) overrun_q <= 1'b1;
        else           pending_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          prog_a_q <= 1'b1;
          if (pending_q || time_unit) begin
            idx_q     <= '0;
            pending_q <= pending_q && time_unit;
            prog_a_q  <= 1'b0;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          if (slot_fire) begin
            out_tag_q <= tag_rd;
            out_ct_q  <= Nct'(1);
            out_v_q   <= 1'b1;
            state_q   <= EMIT;
          end else if (last_slot) begin
            prog_a_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        EMIT: begin
          if (out_a) begin
            out_v_q <= 1'b0;
            if (last_slot) begin
              prog_a_q <= 1'b1;
              state_q  <= IDLE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= SCAN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prog_a  = prog_a_q;
  assign out_tag = out_tag_q;
  assign out_ct  = out_ct_q;
  assign out_v   = out_v_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_spike_generator_array.sv
// Directed self-checking bench for spike_generator_array: schedules, backpressure, inert slots,
// overrun, program/time_unit collision and reset during emit.
module tb_spike_generator_array;

  logic          clk = 1'b0;
  logic          reset;
  logic          time_unit;
  logic [7:0]    gens_used;
  logic [255:0]  gens_en;
  logic [7:0]    prog_gen_idx;
  logic [15:0]   prog_period;
  logic [15:0]   prog_ticks;
  logic [10:0]   prog_tag;
  logic          prog_v;
  logic          prog_a;
  logic [10:0]   out_tag;
  logic [9:0]    out_ct;
  logic          out_v;
  logic          out_a;
  logic          overrun;

  int checks = 0;
  int failures = 0;
  logic [10:0] got[$];

  spike_generator_array #(.Ngens(8), .Nperiod(16), .Ntag(11), .Nct(10)) dut (
    .clk(clk), .reset(reset), .time_unit(time_unit), .gens_used(gens_used), .gens_en(gens_en),
    .prog_gen_idx(prog_gen_idx), .prog_period(prog_period), .prog_ticks(prog_ticks),
    .prog_tag(prog_tag), .prog_v(prog_v), .prog_a(prog_a), .out_tag(out_tag), .out_ct(out_ct),
    .out_v(out_v), .out_a(out_a), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic program_gen(input logic [7:0] idx, input logic [15:0] per,
                             input logic [15:0] tks, input logic [10:0] tg);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (prog_a) begin seen = 1'b1; break; end
      tick();
    end
    check("prog_ready", {31'd0, seen}, 32'd1);
    prog_gen_idx = idx; prog_period = per; prog_ticks = tks; prog_tag = tg;
    prog_v = 1'b1;
    tick();
    prog_v = 1'b0;
  endtask

  // Collects transferred words until the FSM returns to IDLE (prog_a high).
  task automatic collect(input int budget);
    logic done;
    done = 1'b0;
    got.delete();
    for (int c = 0; c < budget; c++) begin
      if (out_v && out_a) begin
        got.push_back(out_tag);
        check("out_ct", {22'd0, out_ct}, 32'd1);
      end
      tick();
      if (prog_a) begin done = 1'b1; break; end
    end
    check("scan_done", {31'd0, done}, 32'd1);
  endtask

  task automatic unit_run();
    time_unit = 1'b1;
    tick();
    time_unit = 1'b0;
    collect(600);
  endtask

  task automatic expect_emits(input string tag, input int n, input logic [10:0] tg);
    check(tag, got.size(), n);
    foreach (got[i]) check({tag, "_tag"}, {21'd0, got[i]}, {21'd0, tg});
  endtask

  initial begin
    int bad;
    int total;
    reset = 1'b1; time_unit = 1'b0; gens_used = '0; gens_en = '0;
    prog_gen_idx = '0; prog_period = '0; prog_ticks = '0; prog_tag = '0; prog_v = 1'b0; out_a = 1'b1;
    tick(); tick();
    check("rst_out_v", {31'd0, out_v}, 32'd0);
    check("rst_out_tag", {21'd0, out_tag}, 32'd0);
    check("rst_out_ct", {22'd0, out_ct}, 32'd0);
    check("rst_prog_a", {31'd0, prog_a}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_prog_a", {31'd0, prog_a}, 32'd1);

    // 1: period 4, phase 0 -> units 0, 4, 8
    program_gen(8'd3, 16'd4, 16'd0, 11'h155);
    gens_used = 8'd3; gens_en = '0; gens_en[3] = 1'b1;
    for (int u = 0; u < 9; u++) begin
      unit_run();
      expect_emits("t1_unit", (u % 4 == 0) ? 1 : 0, 11'h155);
    end

    // 2: backpressure holds 0x10, then 0x11 follows
    program_gen(8'd0, 16'd1, 16'd0, 11'h010);
    program_gen(8'd1, 16'd1, 16'd0, 11'h011);
    gens_used = 8'd1; gens_en = '0; gens_en[0] = 1'b1; gens_en[1] = 1'b1;
    out_a = 1'b0;
    time_unit = 1'b1; tick(); time_unit = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!(out_v === 1'b1 && out_tag === 11'h010)) bad++;
    end
    check("t2_hold", bad, 0);
    out_a = 1'b1;
    collect(100);
    check("t2_count", got.size(), 2);
    if (got.size() == 2) begin
      check("t2_first", {21'd0, got[0]}, 32'h010);
      check("t2_second", {21'd0, got[1]}, 32'h011);
    end

    // 3: inert period-0 slot and disabled slot
    reset = 1'b1; tick(); reset = 1'b0; tick();
    program_gen(8'd2, 16'd0, 16'd0, 11'h022);
    program_gen(8'd5, 16'd3, 16'd1, 11'h055);
    gens_used = 8'd5; gens_en = '0; gens_en[2] = 1'b1;
    total = 0;
    for (int u = 0; u < 10; u++) begin
      unit_run();
      total += got.size();
    end
    check("t3_silent", total, 0);
    gens_en[5] = 1'b1;
    for (int u = 0; u < 5; u++) begin
      unit_run();
      expect_emits("t3_en_unit", (u == 1 || u == 4) ? 1 : 0, 11'h055);
    end

    // 4: three units during one stalled scan -> one extra scan, sticky overrun
    reset = 1'b1; tick(); reset = 1'b0; tick();
    program_gen(8'd0, 16'd1, 16'd0, 11'h044);
    gens_used = 8'd0; gens_en = '0; gens_en[0] = 1'b1;
    out_a = 1'b0;
    time_unit = 1'b1; tick(); time_unit = 1'b0; tick();
    check("t4_stalled", {31'd0, out_v}, 32'd1);
    for (int p = 0; p < 3; p++) begin
      time_unit = 1'b1; tick(); time_unit = 1'b0; tick();
    end
    check("t4_overrun", {31'd0, overrun}, 32'd1);
    out_a = 1'b1;
    collect(100);
    expect_emits("t4_scan", 1, 11'h044);
    collect(100);
    expect_emits("t4_extra", 1, 11'h044);
    collect(100);
    expect_emits("t4_no_more", 0, 11'h044);
    check("t4_sticky", {31'd0, overrun}, 32'd1);

    // 5: program write and time_unit in the same IDLE cycle
    reset = 1'b1; tick(); reset = 1'b0; tick();
    gens_used = 8'd0; gens_en = '0; gens_en[0] = 1'b1;
    prog_gen_idx = 8'd0; prog_period = 16'd2; prog_ticks = 16'd0; prog_tag = 11'h007;
    prog_v = 1'b1; time_unit = 1'b1;
    check("t5_prog_a", {31'd0, prog_a}, 32'd1);
    tick();
    prog_v = 1'b0; time_unit = 1'b0;
    collect(100);
    expect_emits("t5_same_unit", 1, 11'h007);
    unit_run();
    expect_emits("t5_unit1", 0, 11'h007);
    unit_run();
    expect_emits("t5_unit2", 1, 11'h007);

    // 6: reset while in EMIT
    program_gen(8'd0, 16'd1, 16'd0, 11'h009);
    out_a = 1'b0;
    time_unit = 1'b1; tick(); time_unit = 1'b0; tick();
    check("t6_emit", {31'd0, out_v}, 32'd1);
    for (int p = 0; p < 2; p++) begin
      time_unit = 1'b1; tick(); time_unit = 1'b0; tick();
    end
    check("t6_pre_overrun", {31'd0, overrun}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_out_v", {31'd0, out_v}, 32'd0);
    check("t6_overrun", {31'd0, overrun}, 32'd0);
    check("t6_prog_a", {31'd0, prog_a}, 32'd0);
    out_a = 1'b1;
    tick();
    unit_run();
    expect_emits("t6_after", 0, 11'h009);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
